// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, FSM states, default width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_mul.sv
// Iterative unsigned shift-add multiplier with a fixed WIDTH-cycle latency.
// done is asserted combinationally on the edge that performs the last step, and
// prod presents the accumulator including that step, so the caller can capture it
// on the same edge.
module alu_shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  assign done = busy && (cnt == CNT_W'(WIDTH - 1));
  assign prod = acc_next;

  // Step register: load operands on start, then one shift-add step per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/response controller: accepts a request on a valid/ready handshake,
// executes logic/add/sub in one cycle or multiply iteratively, and holds the
// registered result with flags until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_t             state;
  state_t             state_next;
  logic               load;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   y_next;
  logic               ovf_next;
  logic               err_next;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_ovf;
  logic               alu_err;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  alu_shift_add_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (a),
    .b    (b),
    .done (mul_done),
    .prod (prod)
  );

  // Single-cycle datapath for logic, add and sub, with signed-overflow detection.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    alu_y   = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (f)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_NAND: alu_y = ~(a & b);
      OP_NOR:  alu_y = ~(a | b);
      OP_ADD: begin
        alu_y   = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y   = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ILL:  alu_err = 1'b1;
      default: alu_y = '0;
    endcase
  end

  // Next-state logic and result selection for the result registers.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    mul_start  = 1'b0;
    y_next     = '0;
    ovf_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (f == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end else begin
            load       = 1'b1;
            y_next     = alu_y;
            ovf_next   = alu_ovf;
            err_next   = alu_err;
            state_next = DONE;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          load       = 1'b1;
          y_next     = prod[WIDTH-1:0];
          ovf_next   = |prod[2*WIDTH-1:WIDTH];
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Result and flag registers, held until the next completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y    <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else if (load) begin
      y    <= y_next;
      zero <= (y_next == '0);
      ovf  <= ovf_next;
      err  <= err_next;
    end
  end

endmodule
